// File: rtl/timer_reg_master.sv
// rtl/timer_reg_master.sv - register bus initiator with command FIFO for the timer
//
// Takes read/write commands from a host over a valid/ready channel, buffers them
// in a FIFO and issues each as a single-cycle strobe on the register bus. One
// response is returned per command.
//
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        host command handshake
//   cmd_write/addr/wdata       command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready        response handshake
//   rsp_write/err/rdata        response payload (rdata 0 for writes and errors)
//   addr, wr_en, rd_en, mod_en,
//   wdata                      registered register-bus outputs
//   rdata                      register-bus read data, sampled RD_LAT cycles after rd_en
module timer_reg_master #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic              mod_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------
    // Command FIFO: pointers carry one extra wrap bit to tell full from empty
    // ---------------------------------------------------------------
    logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wp_q, wp_d;
    logic [PTR_W:0]    rp_q, rp_d;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [ENT_W-1:0]  head;
    logic              head_write;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata;
    logic              head_misaligned;

    assign fifo_empty = (wp_q == rp_q);
    assign fifo_full  = (wp_q[PTR_W] != rp_q[PTR_W]) &&
                        (wp_q[PTR_W-1:0] == rp_q[PTR_W-1:0]);
    // Depends only on FIFO state, so a same-cycle pop never frees a slot early.
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;

    assign head            = mem_q[rp_q[PTR_W-1:0]];
    assign head_write      = head[ENT_W-1];
    assign head_addr       = head[DATA_W +: ADDR_W];
    assign head_wdata      = head[DATA_W-1:0];
    assign head_misaligned = (head_addr[1:0] != 2'b00);

    assign wp_d = push ? (wp_q + (PTR_W+1)'(1)) : wp_q;
    assign rp_d = pop  ? (rp_q + (PTR_W+1)'(1)) : rp_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q[PTR_W-1:0]] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // ---------------------------------------------------------------
    // Transaction FSM
    // ---------------------------------------------------------------
    state_t            state_q, state_d;
    logic              cur_write_q, cur_write_d;
    logic              cur_err_q, cur_err_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] cur_wdata_q, cur_wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              mod_en_q, mod_en_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    always_comb begin
        state_d     = state_q;
        cur_write_d = cur_write_q;
        cur_err_d   = cur_err_q;
        cur_addr_d  = cur_addr_q;
        cur_wdata_d = cur_wdata_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        mod_en_d    = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    cur_write_d = head_write;
                    cur_addr_d  = head_addr;
                    cur_wdata_d = head_wdata;
                    cur_err_d   = head_misaligned;
                    // Misaligned commands never touch the bus.
                    state_d     = head_misaligned ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Bus outputs are registered, so the strobe appears in the
                // cycle after ISSUE.
                addr_d   = cur_addr_q;
                mod_en_d = 1'b1;
                if (cur_write_q) begin
                    wr_en_d = 1'b1;
                    wdata_d = cur_wdata_q;
                    state_d = ST_RESP;
                end else begin
                    rd_en_d = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // First WAIT cycle is the strobe cycle; rdata is taken at the
                // end of the cycle RD_LAT after it.
                if (cnt_q == CNT_W'(RD_LAT)) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = rdata;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_write_d = cur_write_q;
                    rsp_err_d   = cur_err_q;
                    rsp_rdata_d = '0;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp_q        <= '0;
            rp_q        <= '0;
            state_q     <= ST_IDLE;
            cur_write_q <= 1'b0;
            cur_err_q   <= 1'b0;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            mod_en_q    <= 1'b0;
            wdata_q     <= '0;
        end else begin
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            state_q     <= state_d;
            cur_write_q <= cur_write_d;
            cur_err_q   <= cur_err_d;
            cur_addr_q  <= cur_addr_d;
            cur_wdata_q <= cur_wdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            mod_en_q    <= mod_en_d;
            wdata_q     <= wdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign addr      = addr_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign mod_en    = mod_en_q;
    assign wdata     = wdata_q;

endmodule
